store_v: RTL

- DRAM write engine directly downstream of the STORE execution stage.
- Accepts signed 8-bit vector tiles over a valid/ready handshake and serialises each tile into DRAM_WIDTH-bit write beats starting at a byte address.
- Masks bytes beyond the vector length and pulses done after the final beat is acknowledged.

---
 rtl/store_v_pkg.sv | 22 ++
 rtl/store_v_tile_beat_serializer.sv | 39 +++
 rtl/store_v.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/store_v_pkg.sv
// Shared types and geometry helpers for the store_v DRAM write engine.
package store_v_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_TILE = 2'd1,
      WRITE     = 2'd2,
      DONE      = 2'd3
   } store_v_state_t;

   localparam int LEN_W   = 10;
   localparam int BEATS_W = 11;

   function automatic int beat_bytes(input int dram_width);
      return dram_width / 8;
   endfunction

   function automatic int beats_per_tile(input int tile_width, input int dram_width);
      return tile_width / dram_width;
   endfunction

endpackage

// File: rtl/store_v_tile_beat_serializer.sv
// Selects one DRAM beat out of the captured tile and builds its byte strobes
// from the running byte offset against the element count.
module tile_beat_serializer
   import store_v_pkg::*;
#(
   parameter int TILE_WIDTH = 256,
   parameter int DRAM_WIDTH = 64,
   parameter int OFF_W      = 14,
   parameter int BYTES      = beat_bytes(DRAM_WIDTH),
   parameter int BEATS      = beats_per_tile(TILE_WIDTH, DRAM_WIDTH),
   parameter int BIDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic [TILE_WIDTH-1:0] tile,
   input  logic [BIDX_W-1:0]     beat_idx,
   input  logic [OFF_W-1:0]      byte_off,
   input  logic [LEN_W-1:0]      length,
   output logic [DRAM_WIDTH-1:0] wdata,
   output logic [BYTES-1:0]      wstrb
);

   localparam int CMP_W = ((OFF_W > LEN_W) ? OFF_W : LEN_W) + 1;

   logic [BEATS-1:0][DRAM_WIDTH-1:0] beats;

   assign beats = tile;

   always_comb begin
      wdata = beats[beat_idx];
   end

   // Widened compare so byte_off + b can never wrap below length.
   always_comb begin
      wstrb = '0;
      for (int b = 0; b < BYTES; b++) begin
         wstrb[b] = (CMP_W'(byte_off) + CMP_W'(b)) < CMP_W'(length);
      end
   end

endmodule

// File: rtl/store_v.sv
// DRAM write engine: serialises signed 8-bit tiles into masked write beats.
// Optional running checksum output enabled by defining STORE_V_CHECKSUM_EN.
module store_v
   import store_v_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int TILE_WIDTH = 256,
   parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
   parameter int ADDR_WIDTH = 24,
   parameter int DRAM_WIDTH = 64
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic [ADDR_WIDTH-1:0]                     addr,
   input  logic [LEN_W-1:0]                          length,
   input  logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_in,
   input  logic                                      tile_valid,
   output logic                                      tile_ready,
   output logic                                      mem_req,
   output logic [ADDR_WIDTH-1:0]                     mem_addr,
   output logic [DRAM_WIDTH-1:0]                     mem_wdata,
   output logic [DRAM_WIDTH/8-1:0]                   mem_wstrb,
   input  logic                                      mem_ack,
   output logic                                      busy,
   output logic                                      done
`ifdef STORE_V_CHECKSUM_EN
   ,
   output logic [DRAM_WIDTH-1:0]                     checksum
`endif
);

   localparam int BEAT_BYTES     = beat_bytes(DRAM_WIDTH);
   localparam int BEATS_PER_TILE = beats_per_tile(TILE_WIDTH, DRAM_WIDTH);
   localparam int BB_LOG2        = $clog2(BEAT_BYTES);
   localparam int BIDX_W         = (BEATS_PER_TILE > 1) ? $clog2(BEATS_PER_TILE) : 1;
   localparam int OFF_W          = BEATS_W + BB_LOG2;

   // state     | meaning
   // IDLE      | waiting for start
   // WAIT_TILE | tile_ready high, waiting for the next tile
   // WRITE     | issuing beats of the captured tile
   // DONE      | one-cycle completion pulse
   store_v_state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] base_q;
   logic [LEN_W-1:0]      len_q;
   logic [BEATS_W-1:0]    total_q;
   logic [BEATS_W-1:0]    beats_done;
   logic [BIDX_W-1:0]     beat_idx;
   logic [TILE_WIDTH-1:0] tile_q;

   logic                  start_ok;
   logic                  tile_hs;
   logic                  beat_hs;
   logic                  last_beat;
   logic                  tile_end;
   logic [BEATS_W-1:0]    total_calc;
   logic [ADDR_WIDTH-1:0] addr_aligned;
   logic [OFF_W-1:0]      byte_off;
   logic [ADDR_WIDTH-1:0] beat_addr;
   logic [DRAM_WIDTH-1:0] beat_data;
   logic [BEAT_BYTES-1:0] beat_strb;

   assign start_ok     = (state == IDLE) && start;
   assign tile_hs      = tile_ready && tile_valid;
   assign beat_hs      = mem_req && mem_ack;
   assign last_beat    = (beats_done + BEATS_W'(1)) == total_q;
   assign tile_end     = beat_idx == BIDX_W'(BEATS_PER_TILE - 1);
   assign total_calc   = (BEATS_W'(length) + BEATS_W'(BEAT_BYTES - 1)) >> BB_LOG2;
   assign addr_aligned = addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
   assign byte_off     = {beats_done, {BB_LOG2{1'b0}}};
   assign beat_addr    = base_q + ADDR_WIDTH'(byte_off);

   tile_beat_serializer #(
      .TILE_WIDTH (TILE_WIDTH),
      .DRAM_WIDTH (DRAM_WIDTH),
      .OFF_W      (OFF_W)
   ) u_ser (
      .tile     (tile_q),
      .beat_idx (beat_idx),
      .byte_off (byte_off),
      .length   (len_q),
      .wdata    (beat_data),
      .wstrb    (beat_strb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (length == '0) ? DONE : WAIT_TILE;
            end
         end
         WAIT_TILE: begin
            if (tile_valid) begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            if (mem_ack) begin
               if (last_beat) begin
                  state_nxt = DONE;
               end else if (tile_end) begin
                  state_nxt = WAIT_TILE;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Beat fields are forced to zero outside WRITE so reset clears every output.
   always_comb begin
      tile_ready = 1'b0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_wstrb  = '0;
      busy       = 1'b1;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
         end
         WAIT_TILE: begin
            tile_ready = 1'b1;
         end
         WRITE: begin
            mem_req   = 1'b1;
            mem_addr  = beat_addr;
            mem_wdata = beat_data;
            mem_wstrb = beat_strb;
         end
         DONE: begin
            done = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_q     <= '0;
         len_q      <= '0;
         total_q    <= '0;
         beats_done <= '0;
         beat_idx   <= '0;
         tile_q     <= '0;
      end else begin
         if (start_ok) begin
            base_q     <= addr_aligned;
            len_q      <= length;
            total_q    <= total_calc;
            beats_done <= '0;
         end
         if (tile_hs) begin
            tile_q   <= tile_in;
            beat_idx <= '0;
         end
         if (beat_hs) begin
            beats_done <= beats_done + BEATS_W'(1);
            beat_idx   <= tile_end ? '0 : beat_idx + BIDX_W'(1);
         end
      end
   end

`ifdef STORE_V_CHECKSUM_EN
   logic [DRAM_WIDTH-1:0] strb_mask;

   always_comb begin
      strb_mask = '0;
      for (int b = 0; b < BEAT_BYTES; b++) begin
         strb_mask[b*8 +: 8] = {8{mem_wstrb[b]}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         checksum <= '0;
      end else if (start_ok) begin
         checksum <= '0;
      end else if (beat_hs) begin
         checksum <= checksum ^ (mem_wdata & strb_mask);
      end
   end
`endif

endmodule
